// File: rtl/reg_wb_pkg.sv
// reg_wb_pkg: shared types and constants for the register-file writeback block.
package reg_wb_pkg;

    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 32;
    localparam int REG_ZERO  = 0;
    localparam int NUM_REGS  = 32;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
        logic                 live;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_fifo.sv
// wb_fifo: circular buffer of writeback entries with parallel squash-by-address.
// Popped slots drop their live bit, so the live outputs cover occupied, unsquashed entries only.
module wb_fifo
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                              Clock,
    input  logic                              nReset,
    input  logic                              push,
    input  wb_entry_t                         push_entry,
    input  logic                              pop,
    input  logic                              squash,
    input  logic [WB_ADDR_W-1:0]              squash_addr,
    output wb_entry_t                         head,
    output logic                              full,
    output logic                              empty,
    output logic [DEPTH-1:0]                  live,
    output logic [DEPTH-1:0][WB_ADDR_W-1:0]   addrs
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t     mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            live[i]  = mem[i].live;
            addrs[i] = mem[i].addr;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (squash && mem[i].addr == squash_addr) mem[i].live <= 1'b0;
            if (do_pop) begin
                mem[rd_ptr].live <= 1'b0;
                rd_ptr           <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: sole write-port owner merging the non-stalling ALU path with a queued long-latency path.
// Optional WB_FWD_EN adds a combinational bypass of the in-flight write for decode.
module reg_writeback
    import reg_wb_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic                Clock,
    input  logic                nReset,
    input  logic                AluWrite,
    input  logic [ADDR_W-1:0]   AluAddr,
    input  logic [DATA_W-1:0]   AluData,
    input  logic                LongValid,
    output logic                LongReady,
    input  logic [ADDR_W-1:0]   LongAddr,
    input  logic [DATA_W-1:0]   LongData,
    output logic                RegWrite,
    output logic [ADDR_W-1:0]   RdAddr,
    output logic [DATA_W-1:0]   RdData,
    output logic [NUM_REGS-1:0] Pending,
    output logic                Busy
`ifdef WB_FWD_EN
    ,
    input  logic [ADDR_W-1:0]   FwdAddr,
    output logic                FwdHit,
    output logic [DATA_W-1:0]   FwdData
`endif
);

    logic                            alu_hit;
    logic                            long_ok;
    logic                            pop;
    logic                            bypass;
    logic                            push;
    logic                            full;
    logic                            empty;
    wb_entry_t                       head;
    wb_entry_t                       push_entry;
    logic [DEPTH-1:0]                live;
    logic [DEPTH-1:0][WB_ADDR_W-1:0] addrs;

    // A long result racing an ALU write to the same register is already stale.
    always_comb begin
        alu_hit    = AluWrite && AluAddr != ADDR_W'(REG_ZERO);
        long_ok    = LongValid && !full && LongAddr != ADDR_W'(REG_ZERO) &&
                     !(alu_hit && LongAddr == AluAddr);
        pop        = !alu_hit && !empty;
        bypass     = !alu_hit && empty && long_ok;
        push       = long_ok && !bypass;
        push_entry = '{addr: LongAddr, data: LongData, live: 1'b1};
    end

    assign LongReady = !full;
    assign Busy      = !empty;

    always_comb begin
        Pending = '0;
        for (int i = 0; i < DEPTH; i++)
            if (live[i]) Pending[addrs[i]] = 1'b1;
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .Clock       (Clock),
        .nReset      (nReset),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .squash      (alu_hit),
        .squash_addr (AluAddr),
        .head        (head),
        .full        (full),
        .empty       (empty),
        .live        (live),
        .addrs       (addrs)
    );

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            RegWrite <= 1'b0;
            RdAddr   <= '0;
            RdData   <= '0;
        end else if (alu_hit) begin
            RegWrite <= 1'b1;
            RdAddr   <= AluAddr;
            RdData   <= AluData;
        end else if (pop) begin
            RegWrite <= head.live;
            if (head.live) begin
                RdAddr <= head.addr;
                RdData <= head.data;
            end
        end else if (bypass) begin
            RegWrite <= 1'b1;
            RdAddr   <= LongAddr;
            RdData   <= LongData;
        end else begin
            RegWrite <= 1'b0;
        end
    end

`ifdef WB_FWD_EN
    assign FwdHit  = RegWrite && RdAddr == FwdAddr && FwdAddr != ADDR_W'(REG_ZERO);
    assign FwdData = FwdHit ? RdData : '0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_reg_writeback;
    import reg_wb_pkg::*;

    localparam int DEPTH = 2;

    logic        Clock = 1'b0;
    logic        nReset = 1'b0;
    logic        AluWrite = 1'b0;
    logic [4:0]  AluAddr = '0;
    logic [31:0] AluData = '0;
    logic        LongValid = 1'b0;
    logic        LongReady;
    logic [4:0]  LongAddr = '0;
    logic [31:0] LongData = '0;
    logic        RegWrite;
    logic [4:0]  RdAddr;
    logic [31:0] RdData;
    logic [31:0] Pending;
    logic        Busy;
`ifdef WB_FWD_EN
    logic [4:0]  FwdAddr = '0;
    logic        FwdHit;
    logic [31:0] FwdData;
`endif

    reg_writeback #(.DEPTH(DEPTH)) dut (
        .Clock(Clock), .nReset(nReset),
        .AluWrite(AluWrite), .AluAddr(AluAddr), .AluData(AluData),
        .LongValid(LongValid), .LongReady(LongReady), .LongAddr(LongAddr), .LongData(LongData),
        .RegWrite(RegWrite), .RdAddr(RdAddr), .RdData(RdData),
        .Pending(Pending), .Busy(Busy)
`ifdef WB_FWD_EN
        , .FwdAddr(FwdAddr), .FwdHit(FwdHit), .FwdData(FwdData)
`endif
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        bit          live;
    } ent_t;

    ent_t        q[$];
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_ready;
    logic        pre_ready;
    int          checks = 0;
    int          passes = 0;

    function automatic logic [31:0] m_pending();
        logic [31:0] r = '0;
        foreach (q[i]) if (q[i].live) r[q[i].a] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_we = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    // Advances the reference by one clock using the currently driven inputs.
    task automatic model_step();
        bit alu = AluWrite && AluAddr != 0;
        bit xfer = LongValid && q.size() < DEPTH;
        bit lok = xfer && LongAddr != 0 && !(alu && LongAddr == AluAddr);
        bit byp = 1'b0;
        m_ready = q.size() < DEPTH;
        if (alu) begin
            foreach (q[i]) if (q[i].a == AluAddr) q[i].live = 1'b0;
            m_we = 1'b1; m_addr = AluAddr; m_data = AluData;
        end else if (q.size() > 0) begin
            ent_t h = q.pop_front();
            m_we = h.live;
            if (h.live) begin m_addr = h.a; m_data = h.d; end
        end else if (lok) begin
            byp = 1'b1;
            m_we = 1'b1; m_addr = LongAddr; m_data = LongData;
        end else begin
            m_we = 1'b0;
        end
        if (lok && !byp) q.push_back('{LongAddr, LongData, 1'b1});
    endtask

    task automatic tick(input logic aw, input logic [4:0] aa, input logic [31:0] ad,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
        AluWrite = aw; AluAddr = aa; AluData = ad;
        LongValid = lv; LongAddr = la; LongData = ld;
        #1;
        pre_ready = LongReady;
        model_step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        tick(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        #12;
        checks++;
        if ({RegWrite, RdAddr, RdData, Pending, Busy, LongReady} !== {1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1})
            $display("FAIL reset_state: got we=%b a=%0d d=%h p=%h busy=%b rdy=%b want 0/0/0/0/0/1",
                     RegWrite, RdAddr, RdData, Pending, Busy, LongReady);
        else passes++;
        @(posedge Clock);
        #1;
        nReset = 1'b1;
        model_reset();
    endtask

    task automatic test_alu_only();
        tick(1, 5, 32'h1234, 0, 0, 0);
        checks++;
        if ({RegWrite, RdAddr, RdData, LongReady, pre_ready} !== {1'b1, 5'd5, 32'h1234, 1'b1, 1'b1})
            $display("FAIL alu_only: got we=%b a=%0d d=%h rdy=%b want 1/5/1234/1", RegWrite, RdAddr, RdData, LongReady);
        else passes++;
        idle();
        checks++;
        if ({RegWrite, RdAddr, RdData} !== {1'b0, 5'd5, 32'h1234})
            $display("FAIL alu_idle_hold: got we=%b a=%0d d=%h want 0/5/1234", RegWrite, RdAddr, RdData);
        else passes++;
    endtask

    task automatic test_long_bypass();
        tick(0, 0, 0, 1, 9, 32'hCAFE);
        checks++;
        if ({pre_ready, RegWrite, RdAddr, RdData, Busy} !== {1'b1, 1'b1, 5'd9, 32'hCAFE, 1'b0})
            $display("FAIL long_bypass: got rdy=%b we=%b a=%0d d=%h busy=%b want 1/1/9/cafe/0",
                     pre_ready, RegWrite, RdAddr, RdData, Busy);
        else passes++;
        idle();
    endtask

    task automatic test_collision_fill();
        tick(1, 3, 32'h33, 1, 7, 32'hA);
        checks++;
        if ({RegWrite, RdAddr, RdData, Busy, Pending} !== {1'b1, 5'd3, 32'h33, 1'b1, 32'h80})
            $display("FAIL fill_r3: got we=%b a=%0d d=%h busy=%b p=%h want 1/3/33/1/80", RegWrite, RdAddr, RdData, Busy, Pending);
        else passes++;
        tick(1, 4, 32'h44, 1, 8, 32'hB);
        checks++;
        if ({pre_ready, RegWrite, RdAddr, LongReady, Pending} !== {1'b1, 1'b1, 5'd4, 1'b0, 32'h180})
            $display("FAIL fill_r4_full: got rdy_in=%b we=%b a=%0d rdy=%b p=%h want 1/1/4/0/180",
                     pre_ready, RegWrite, RdAddr, LongReady, Pending);
        else passes++;
        tick(1, 5, 32'h55, 0, 0, 0);
        tick(1, 6, 32'h66, 0, 0, 0);
        checks++;
        if ({RegWrite, RdAddr, RdData, LongReady, Pending} !== {1'b1, 5'd6, 32'h66, 1'b0, 32'h180})
            $display("FAIL fill_r6: got we=%b a=%0d d=%h rdy=%b p=%h want 1/6/66/0/180", RegWrite, RdAddr, RdData, LongReady, Pending);
        else passes++;
        idle();
        checks++;
        if ({RegWrite, RdAddr, RdData, LongReady, Pending} !== {1'b1, 5'd7, 32'hA, 1'b1, 32'h100})
            $display("FAIL drain_r7: got we=%b a=%0d d=%h rdy=%b p=%h want 1/7/a/1/100", RegWrite, RdAddr, RdData, LongReady, Pending);
        else passes++;
        idle();
        checks++;
        if ({RegWrite, RdAddr, RdData, Busy, Pending} !== {1'b1, 5'd8, 32'hB, 1'b0, 32'h0})
            $display("FAIL drain_r8: got we=%b a=%0d d=%h busy=%b p=%h want 1/8/b/0/0", RegWrite, RdAddr, RdData, Busy, Pending);
        else passes++;
        idle();
        checks++;
        if (RegWrite !== 1'b0) $display("FAIL drain_done: got we=%b want 0", RegWrite);
        else passes++;
    endtask

    task automatic test_squash();
        tick(1, 1, 32'h11, 1, 10, 32'h1);
        checks++;
        if (Pending !== 32'h400) $display("FAIL squash_queued: got p=%h want 400", Pending);
        else passes++;
        tick(1, 10, 32'h2, 0, 0, 0);
        checks++;
        if ({RegWrite, RdAddr, RdData, Busy, Pending} !== {1'b1, 5'd10, 32'h2, 1'b1, 32'h0})
            $display("FAIL squash_alu: got we=%b a=%0d d=%h busy=%b p=%h want 1/10/2/1/0", RegWrite, RdAddr, RdData, Busy, Pending);
        else passes++;
        idle();
        checks++;
        if ({RegWrite, RdAddr, RdData, Busy} !== {1'b0, 5'd10, 32'h2, 1'b0})
            $display("FAIL squash_pop: got we=%b a=%0d d=%h busy=%b want 0/10/2/0", RegWrite, RdAddr, RdData, Busy);
        else passes++;
    endtask

    task automatic test_reg0();
        tick(1, 0, 32'hDEAD, 1, 12, 32'h77);
        checks++;
        if ({RegWrite, RdAddr, RdData, Busy} !== {1'b1, 5'd12, 32'h77, 1'b0})
            $display("FAIL reg0_alu_ignored: got we=%b a=%0d d=%h busy=%b want 1/12/77/0", RegWrite, RdAddr, RdData, Busy);
        else passes++;
        tick(0, 0, 0, 1, 0, 32'h99);
        checks++;
        if ({pre_ready, RegWrite, Busy, Pending} !== {1'b1, 1'b0, 1'b0, 32'h0})
            $display("FAIL reg0_long_drop: got rdy=%b we=%b busy=%b p=%h want 1/0/0/0", pre_ready, RegWrite, Busy, Pending);
        else passes++;
    endtask

    task automatic test_reset_mid_queue();
        tick(1, 1, 32'h1, 1, 13, 32'hD);
        tick(1, 2, 32'h2, 1, 14, 32'hE);
        checks++;
        if ({Busy, Pending} !== {1'b1, 32'h6000}) $display("FAIL midq_loaded: got busy=%b p=%h want 1/6000", Busy, Pending);
        else passes++;
        AluWrite = 0; LongValid = 0;
        nReset = 1'b0;
        #1;
        checks++;
        if ({RegWrite, RdAddr, RdData, Busy, Pending} !== {1'b0, 5'd0, 32'd0, 1'b0, 32'd0})
            $display("FAIL midq_reset: got we=%b a=%0d d=%h busy=%b p=%h want all 0", RegWrite, RdAddr, RdData, Busy, Pending);
        else passes++;
        #1;
        nReset = 1'b1;
        model_reset();
        @(posedge Clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            idle();
            checks++;
            if ({RegWrite, Busy} !== 2'b00) $display("FAIL midq_after_%0d: got we=%b busy=%b want 0/0", i, RegWrite, Busy);
            else passes++;
        end
    endtask

    task automatic test_random();
        logic        lv = 1'b0;
        logic [4:0]  la = '0;
        logic [31:0] ld = '0;
        int          errs = 0;
        for (int i = 0; i < 600; i++) begin
            if (!(LongValid && !LongReady)) begin
                lv = $urandom_range(0, 1);
                la = 5'($urandom_range(0, 7));
                ld = $urandom;
            end
            tick(($urandom_range(0, 99) < ((i < 300) ? 80 : 30)) ? 1'b1 : 1'b0,
                 5'($urandom_range(0, 7)), $urandom, lv, la, ld);
            checks++;
            if ({pre_ready, RegWrite, RdAddr, RdData, Busy, Pending} !==
                {m_ready, m_we, m_addr, m_data, q.size() > 0, m_pending()}) begin
                if (errs++ < 10)
                    $display("FAIL random_%0d: got rdy=%b we=%b a=%0d d=%h busy=%b p=%h want %b/%b/%0d/%h/%b/%h", i,
                             pre_ready, RegWrite, RdAddr, RdData, Busy, Pending,
                             m_ready, m_we, m_addr, m_data, q.size() > 0, m_pending());
            end else passes++;
`ifdef WB_FWD_EN
            FwdAddr = 5'($urandom_range(0, 7));
            #1;
            checks++;
            if ({FwdHit, FwdData} !== ((m_we && m_addr == FwdAddr && FwdAddr != 0) ? {1'b1, m_data} : 33'd0))
                $display("FAIL fwd_%0d: got hit=%b d=%h for addr %0d", i, FwdHit, FwdData, FwdAddr);
            else passes++;
`endif
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_alu_only();
        test_long_bypass();
        test_collision_fill();
        test_squash();
        test_reg0();
        test_reset_mid_queue();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
